nios_dct_trace_packer: RTL and testbench

//  Packs 2-bit direct-control-transfer (DCT) codes from the Nios II trace port into a 30-bit

---
 rtl/nios_dct_trace_packer_pkg.sv | 31 +++
 rtl/nios_dct_trace_packer_outreg.sv | 37 +++
 rtl/nios_dct_trace_packer.sv | 151 +++++++++++++++
 tb/tb_nios_dct_trace_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_dct_trace_packer_pkg.sv
// Shared widths, frame type codes and FSM encoding for the DCT trace packer.
// Frames are laid out as {type[1:0], count[3:0], buffer[29:0]}.
package nios_dct_trace_packer_pkg;

    localparam int CODE_W    = 2;
    localparam int MAX_CODES = 15;
    localparam int BUF_W     = CODE_W * MAX_CODES;
    localparam int CNT_W     = 4;
    localparam int FRAME_W   = 2 + CNT_W + BUF_W;

    typedef enum logic [1:0] {
        FT_FULL  = 2'b00,
        FT_FLUSH = 2'b01,
        FT_OVF   = 2'b10,
        FT_END   = 2'b11
    } frame_type_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_ENDING   = 2'b01,
        ST_WAIT_END = 2'b10,
        ST_ENDED    = 2'b11
    } state_e;

    function automatic logic [FRAME_W-1:0] make_frame(input frame_type_e t,
                                                      input logic [CNT_W-1:0] cnt,
                                                      input logic [BUF_W-1:0] buf_v);
        return {t, cnt, buf_v};
    endfunction

endpackage

// File: rtl/nios_dct_trace_packer_outreg.sv
// Single-entry valid/ready holding register for outgoing trace frames.
// Valid/ready: a frame transfers on any edge where valid_o and ready_i are both high;
// data_o is held stable while valid_o is high and ready_i is low.
module nios_dct_frame_outreg
    import nios_dct_trace_packer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] data_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [FRAME_W-1:0] data_o,
    output logic               free_o
);

    logic               valid_q;
    logic [FRAME_W-1:0] data_q;

    // The slot can be refilled on the same edge its current frame is taken.
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/nios_dct_trace_packer.sv
// Packs 2-bit DCT codes into a 15-code shift buffer and emits FULL/FLUSH/OVF/END
// frames through a single holding register, with an end-of-test drain sequence.
module nios_dct_trace_packer
    import nios_dct_trace_packer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dct_valid,
    input  logic [CODE_W-1:0]   dct_code,
    input  logic                flush,
    input  logic                test_ending,
    output logic                frame_valid,
    output logic [FRAME_W-1:0]  frame_data,
    input  logic                frame_ready,
    output logic [BUF_W-1:0]    dct_buffer,
    output logic [CNT_W-1:0]    dct_count,
    output logic                overflow,
    output logic                test_has_ended
);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               overflow_q, overflow_d;

    logic               out_free;
    logic               out_load;
    logic [FRAME_W-1:0] out_data;

    logic [BUF_W-1:0]   shifted;
    logic               code_acc, is_last, full_load, drop;
    logic               ovf_load, flush_eff, flush_srv, flush_load, end_load;

    always_comb begin
        shifted   = {buf_q[BUF_W-CODE_W-1:0], dct_code};
        code_acc  = (state_q == ST_RUN) && dct_valid;
        is_last   = code_acc && (cnt_q == CNT_W'(MAX_CODES - 1));
        full_load = is_last && out_free && !ovf_pend_q;
        drop      = is_last && !full_load;
        ovf_load  = out_free && !full_load && ovf_pend_q;
        // A flush pulse is serviced in its own cycle when the slot allows it.
        flush_eff = flush_pend_q || (flush && (state_q == ST_RUN));
        flush_srv = flush_eff && out_free && !full_load && !ovf_pend_q;
        flush_load = flush_srv && (cnt_q != '0);
        end_load  = (state_q == ST_ENDING) && out_free && !ovf_pend_q && !flush_eff;
    end

    always_comb begin
        out_load = full_load || ovf_load || flush_load || end_load;
        out_data = '0;
        if (full_load) begin
            out_data = make_frame(FT_FULL, CNT_W'(MAX_CODES), shifted);
        end else if (ovf_load) begin
            out_data = make_frame(FT_OVF, '0, '0);
        end else if (flush_load) begin
            out_data = make_frame(FT_FLUSH, cnt_q, buf_q);
        end else if (end_load) begin
            out_data = make_frame(FT_END, '0, '0);
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        ovf_pend_d   = ovf_pend_q;
        overflow_d   = overflow_q;

        if (flush_load) begin
            // A code landing on the flush edge opens the next buffer.
            buf_d = code_acc ? {{(BUF_W-CODE_W){1'b0}}, dct_code} : '0;
            cnt_d = code_acc ? CNT_W'(1) : '0;
        end else if (full_load) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (code_acc && !drop) begin
            buf_d = shifted;
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush_srv) begin
            flush_pend_d = 1'b0;
        end else if (flush_eff) begin
            flush_pend_d = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end
        if (ovf_load) begin
            ovf_pend_d = 1'b0;
        end else if (drop) begin
            ovf_pend_d = 1'b1;
        end

        unique case (state_q)
            ST_RUN: begin
                if (test_ending) begin
                    state_d      = ST_ENDING;
                    flush_pend_d = 1'b1;
                end
            end
            ST_ENDING: begin
                if (end_load) state_d = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (frame_valid && frame_ready) state_d = ST_ENDED;
            end
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            ovf_pend_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            ovf_pend_q   <= ovf_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    nios_dct_frame_outreg u_outreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (out_load),
        .data_i  (out_data),
        .ready_i (frame_ready),
        .valid_o (frame_valid),
        .data_o  (frame_data),
        .free_o  (out_free)
    );

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign overflow       = overflow_q;
    assign test_has_ended = (state_q == ST_ENDED);

endmodule

// File: tb/tb_nios_dct_trace_packer.sv
// Scoreboard bench for nios_dct_trace_packer: expected frames are queued as codes are
// driven and checked by a monitor at each accepted handshake.
module tb_nios_dct_trace_packer;

    logic        clk;
    logic        reset_n;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        test_ending;
    logic        frame_valid;
    logic [35:0] frame_data;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_has_ended;

    logic [35:0] exp_q[$];
    logic [35:0] exp_f;
    logic [29:0] mbuf;
    int          mcnt;
    int          total;
    int          bad;

    nios_dct_trace_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_valid      (dct_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor_unexpected: got frame %h, required no frame", frame_data);
            end else begin
                exp_f = exp_q.pop_front();
                if (frame_data !== exp_f) begin
                    bad++;
                    $display("FAIL monitor_frame: got %h, required %h", frame_data, exp_f);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_code(input logic [1:0] c);
        mbuf = {mbuf[27:0], c};
        mcnt++;
        if (mcnt == 15) begin
            exp_q.push_back({2'b00, 4'd15, mbuf});
            mbuf = '0;
            mcnt = 0;
        end
        dct_valid = 1'b1;
        dct_code  = c;
        step();
        dct_valid = 1'b0;
    endtask

    task automatic do_flush();
        if (mcnt > 0) exp_q.push_back({2'b01, 4'(mcnt), mbuf});
        flush = 1'b1;
        step();
        flush = 1'b0;
        mbuf  = '0;
        mcnt  = 0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        dct_valid   = 1'b0;
        dct_code    = 2'b00;
        flush       = 1'b0;
        test_ending = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        mbuf = '0;
        mcnt = 0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d frames outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        frame_ready = 1'b1;
        do_reset();
        total++;
        if ({frame_valid, frame_data, dct_buffer, dct_count, overflow, test_has_ended} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h b=%h c=%0d o=%b e=%b, required all 0",
                     frame_valid, frame_data, dct_buffer, dct_count, overflow, test_has_ended);
        end
    endtask

    task automatic test_full();
        frame_ready = 1'b1;
        for (int i = 0; i < 14; i++) pack_code(2'((i + 1) % 4));
        total++;
        if (dct_count !== 4'd14) begin
            bad++;
            $display("FAIL full_count14: got %0d, required 14", dct_count);
        end
        total++;
        if (dct_buffer !== mbuf) begin
            bad++;
            $display("FAIL full_buffer14: got %h, required %h", dct_buffer, mbuf);
        end
        pack_code(2'd3);
        total++;
        if (dct_count !== 4'd0 || dct_buffer !== 30'd0) begin
            bad++;
            $display("FAIL full_cleared: got count %0d buffer %h, required 0 and 0", dct_count, dct_buffer);
        end
        wait_drain("full");
    endtask

    task automatic test_flush();
        frame_ready = 1'b1;
        for (int i = 0; i < 5; i++) pack_code(2'($urandom_range(0, 3)));
        do_flush();
        total++;
        if (dct_count !== 4'd0) begin
            bad++;
            $display("FAIL flush_count: got %0d, required 0", dct_count);
        end
        do_flush();
        repeat (4) step();
        wait_drain("flush");
    endtask

    task automatic test_flush_with_code();
        logic [1:0] c;
        frame_ready = 1'b1;
        for (int i = 0; i < 3; i++) pack_code(2'($urandom_range(0, 3)));
        c = 2'($urandom_range(1, 3));
        exp_q.push_back({2'b01, 4'd3, mbuf});
        flush = 1'b1;
        dct_valid = 1'b1;
        dct_code = c;
        step();
        flush = 1'b0;
        dct_valid = 1'b0;
        mbuf = {28'd0, c};
        mcnt = 1;
        total++;
        if (dct_count !== 4'd1 || dct_buffer !== mbuf) begin
            bad++;
            $display("FAIL flush_code_newbuf: got count %0d buffer %h, required 1 and %h", dct_count, dct_buffer, mbuf);
        end
        do_flush();
        wait_drain("flush_code");
    endtask

    task automatic test_overflow();
        logic [29:0] b;
        logic [1:0]  c;
        frame_ready = 1'b0;
        b = '0;
        for (int i = 0; i < 15; i++) begin
            c = 2'($urandom_range(0, 3));
            b = {b[27:0], c};
            dct_valid = 1'b1; dct_code = c; step();
        end
        exp_q.push_back({2'b00, 4'd15, b});
        b = '0;
        for (int i = 0; i < 14; i++) begin
            c = 2'($urandom_range(0, 3));
            b = {b[27:0], c};
            dct_valid = 1'b1; dct_code = c; step();
        end
        dct_valid = 1'b1; dct_code = 2'($urandom_range(0, 3)); step();
        dct_valid = 1'b0;
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: got %b, required 1", overflow);
        end
        total++;
        if (dct_count !== 4'd14 || dct_buffer !== b) begin
            bad++;
            $display("FAIL ovf_hold: got count %0d buffer %h, required 14 and %h", dct_count, dct_buffer, b);
        end
        total++;
        if (frame_valid !== 1'b1 || frame_data !== exp_q[0]) begin
            bad++;
            $display("FAIL ovf_stable: got v=%b d=%h, required 1 and %h", frame_valid, frame_data, exp_q[0]);
        end
        exp_q.push_back({2'b10, 4'd0, 30'd0});
        frame_ready = 1'b1;
        repeat (2) step();
        c = 2'($urandom_range(0, 3));
        exp_q.push_back({2'b00, 4'd15, b[27:0], c});
        dct_valid = 1'b1; dct_code = c; step();
        dct_valid = 1'b0;
        wait_drain("ovf");
        total++;
        if (dct_count !== 4'd0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after: got count %0d overflow %b, required 0 and 1", dct_count, overflow);
        end
        mbuf = '0;
        mcnt = 0;
    endtask

    task automatic test_end();
        bit seen;
        frame_ready = 1'b1;
        for (int i = 0; i < 7; i++) pack_code(2'($urandom_range(0, 3)));
        exp_q.push_back({2'b01, 4'd7, mbuf});
        exp_q.push_back({2'b11, 4'd0, 30'd0});
        mbuf = '0;
        mcnt = 0;
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_valid && frame_ready && frame_data[35:34] == 2'b11) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL end_frame_seen: got no END frame in 20 cycles, required one");
        end
        total++;
        if (test_has_ended !== 1'b0) begin
            bad++;
            $display("FAIL end_flag_early: got %b, required 0", test_has_ended);
        end
        @(negedge clk);
        total++;
        if (test_has_ended !== 1'b1 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL end_flag: got ended=%b valid=%b, required 1 and 0", test_has_ended, frame_valid);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            dct_valid = 1'b1; dct_code = 2'($urandom_range(0, 3)); step();
        end
        dct_valid = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        repeat (3) step();
        total++;
        if (dct_count !== 4'd0 || dct_buffer !== 30'd0 || frame_valid !== 1'b0 || test_has_ended !== 1'b1) begin
            bad++;
            $display("FAIL end_ignore: got count %0d buffer %h valid %b ended %b, required 0 0 0 1",
                     dct_count, dct_buffer, frame_valid, test_has_ended);
        end
        wait_drain("end");
    endtask

    task automatic test_end_on_full();
        logic [1:0] c;
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < 14; i++) pack_code(2'($urandom_range(0, 3)));
        c = 2'($urandom_range(0, 3));
        exp_q.push_back({2'b00, 4'd15, mbuf[27:0], c});
        exp_q.push_back({2'b11, 4'd0, 30'd0});
        dct_valid = 1'b1; dct_code = c; test_ending = 1'b1;
        step();
        dct_valid = 1'b0; test_ending = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (test_has_ended) break;
            step();
        end
        total++;
        if (test_has_ended !== 1'b1) begin
            bad++;
            $display("FAIL end_full_ended: got %b, required 1", test_has_ended);
        end
        wait_drain("end_full");
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            dct_valid = 1'b1; dct_code = 2'($urandom_range(0, 3)); step();
        end
        dct_valid = 1'b0;
        total++;
        if (frame_valid !== 1'b1 || dct_count !== 4'd3) begin
            bad++;
            $display("FAIL rst_mid_pre: got valid %b count %0d, required 1 and 3", frame_valid, dct_count);
        end
        reset_n = 1'b0;
        step();
        total++;
        if ({frame_valid, frame_data, dct_buffer, dct_count, overflow, test_has_ended} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got v=%b d=%h b=%h c=%0d, required all 0",
                     frame_valid, frame_data, dct_buffer, dct_count);
        end
        reset_n = 1'b1;
        frame_ready = 1'b1;
        mbuf = '0;
        mcnt = 0;
        for (int i = 0; i < 15; i++) pack_code(2'($urandom_range(0, 3)));
        wait_drain("rst_mid");
    endtask

    initial begin
        total = 0;
        bad = 0;
        mbuf = '0;
        mcnt = 0;
        reset_n = 1'b0;
        dct_valid = 1'b0;
        dct_code = 2'b00;
        flush = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b1;
        test_reset();
        test_full();
        test_flush();
        test_flush_with_code();
        test_overflow();
        test_end();
        test_end_on_full();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
